// File: rtl/regfile_access_ctrl_pkg.sv
// Shared types and constants for the two-client register file access controller.
package regfile_access_ctrl_pkg;

   localparam int DW_DEF = 16;
   localparam int AW_DEF = 4;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

endpackage

// File: rtl/regfile_access_ctrl_rr_arb2.sv
// Two-way round-robin grant: on a tie the client that did not win last time is chosen.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Arbitrates two clients onto a falling-edge register file; one access cycle per request,
// then returns read operands or a write acknowledge to the granted client.
module regfile_access_ctrl
   import regfile_access_ctrl_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      req_valid,
   output logic [1:0]      req_ready,
   input  logic [1:0]      req_write,
   input  logic [2*AW-1:0] req_src1,
   input  logic [2*AW-1:0] req_src2,
   input  logic [2*AW-1:0] req_src3,
   input  logic [2*AW-1:0] req_dst,
   input  logic [2*DW-1:0] req_wdata,
   output logic [1:0]      rsp_valid,
   input  logic [1:0]      rsp_ready,
   output logic            rsp_write,
   output logic [DW-1:0]   rsp_a,
   output logic [DW-1:0]   rsp_b,
   output logic [DW-1:0]   rsp_c,
   output logic            regread,
   output logic            regwrite,
   output logic [AW-1:0]   readregsrc1,
   output logic [AW-1:0]   readregsrc2,
   output logic [AW-1:0]   readregsrc3,
   output logic [AW-1:0]   regwritedst,
   output logic [DW-1:0]   writedata,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   input  logic [DW-1:0]   c
);

   state_t state, state_nxt;
   logic   last_grant;
   logic   grant;
   logic   op;
   logic   [1:0] gnt;
   logic   hs;
   logic   sel;

   logic [1:0][AW-1:0] src1_c, src2_c, src3_c, dst_c;
   logic [1:0][DW-1:0] wdata_c;

   for (genvar i = 0; i < 2; i++) begin : g_unpack
      assign src1_c[i]  = req_src1[i*AW +: AW];
      assign src2_c[i]  = req_src2[i*AW +: AW];
      assign src3_c[i]  = req_src3[i*AW +: AW];
      assign dst_c[i]   = req_dst[i*AW +: AW];
      assign wdata_c[i] = req_wdata[i*DW +: DW];
   end

   rr_arb2 u_arb (
      .req  (req_valid),
      .last (last_grant),
      .gnt  (gnt)
   );

   // gnt is already masked by req_valid, so any ready bit is a handshake
   assign req_ready = (state == ST_IDLE) ? gnt : 2'b00;
   assign hs        = |req_ready;
   assign sel       = gnt[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (hs) state_nxt = ST_ACCESS;
         ST_ACCESS: state_nxt = ST_RESP;
         ST_RESP:   if (rsp_ready[grant]) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant  <= 1'b1;
         grant       <= 1'b0;
         op          <= OP_READ;
         regread     <= 1'b0;
         regwrite    <= 1'b0;
         readregsrc1 <= '0;
         readregsrc2 <= '0;
         readregsrc3 <= '0;
         regwritedst <= '0;
         writedata   <= '0;
         rsp_valid   <= 2'b00;
         rsp_write   <= 1'b0;
         rsp_a       <= '0;
         rsp_b       <= '0;
         rsp_c       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (hs) begin
                  readregsrc1 <= src1_c[sel];
                  readregsrc2 <= src2_c[sel];
                  readregsrc3 <= src3_c[sel];
                  regwritedst <= dst_c[sel];
                  writedata   <= wdata_c[sel];
                  op          <= req_write[sel];
                  regread     <= (req_write[sel] == OP_READ);
                  regwrite    <= (req_write[sel] == OP_WRITE);
                  last_grant  <= sel;
                  grant       <= sel;
               end
            end
            ST_ACCESS: begin
               // register file drove a/b/c on the falling edge inside this cycle
               if (op == OP_READ) begin
                  rsp_a <= a;
                  rsp_b <= b;
                  rsp_c <= c;
               end
               rsp_write        <= op;
               rsp_valid[grant] <= 1'b1;
               regread          <= 1'b0;
               regwrite         <= 1'b0;
            end
            ST_RESP: begin
               if (rsp_ready[grant]) rsp_valid <= 2'b00;
            end
            default: ;
         endcase
      end
   end

endmodule
